// File: rtl/fetch_prefetch_pkg.sv
// Shared types for the fetch/prefetch stage: FSM state encoding and the
// 16-bit word and queue-entry types used by the default LC-3b configuration.
package fetch_prefetch_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_REQ,
        FS_DISCARD
    } fetch_state_t;

    typedef struct packed {
        lc3b_word pc;
        lc3b_word instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_fifo.sv
// Circular prefetch queue: DEPTH entries (power of two), push/pop/flush,
// occupancy count, full/empty. Storage holds data only and is not reset.
module fetch_prefetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Entry storage: written on push, flush does not need to clear it
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally mod DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage with prefetch queue. Owns the fetch PC, issues
// held-handshake reads, queues returned words with their PCs and hands the
// head to decode. Redirects flush the queue and drop any in-flight word.
// Optional: define FETCH_PREFETCH_STATS_EN to add stall/redirect counters.
module fetch_prefetch
    import fetch_prefetch_pkg::*;
#(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 16,
    parameter int              DEPTH    = 4,
    parameter int              PC_INC   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_read,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_resp,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pcplus,
    input  logic               id_ready
`ifdef FETCH_PREFETCH_STATS_EN
    ,
    output logic [31:0]        stat_stall_cycles,
    output logic [31:0]        stat_redirects
`endif
);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_t       state, state_nxt;
    logic [ADDR_W-1:0]  fetch_pc, fetch_pc_nxt;
    logic [ADDR_W-1:0]  hold_addr, hold_addr_nxt;
    logic               push, pop, flush;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     count_after;
    logic               full, empty;
    entry_t             push_entry;
    entry_t             head;

    assign push_entry = '{pc: fetch_pc, instr: imem_rdata};

    fetch_prefetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (push_entry),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // State, fetch PC and the address held while discarding a stale read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FS_IDLE;
            fetch_pc  <= RESET_PC;
            hold_addr <= RESET_PC;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            hold_addr <= hold_addr_nxt;
        end
    end

    // Next-state, issue and queue control; redirect overrides push/pop/issue
    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        hold_addr_nxt = hold_addr;
        push          = 1'b0;
        flush         = 1'b0;
        pop           = !empty && id_ready && !redirect_valid;
        count_after   = {1'b0, count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);
        if (redirect_valid) begin
            flush        = 1'b1;
            fetch_pc_nxt = redirect_pc;
            case (state)
                FS_REQ: begin
                    if (imem_resp) begin
                        state_nxt = FS_IDLE;
                    end else begin
                        state_nxt     = FS_DISCARD;
                        hold_addr_nxt = fetch_pc;
                    end
                end
                FS_DISCARD: begin
                    if (imem_resp) begin
                        state_nxt = FS_IDLE;
                    end
                end
                default: state_nxt = FS_IDLE;
            endcase
        end else begin
            case (state)
                FS_IDLE: begin
                    // Nothing in flight, so a single free slot is enough
                    if (!full) begin
                        state_nxt = FS_REQ;
                    end
                end
                FS_REQ: begin
                    if (imem_resp) begin
                        push         = 1'b1;
                        fetch_pc_nxt = fetch_pc + ADDR_W'(PC_INC);
                        // Reissue immediately only if the next word has a slot
                        if (count_after < (CNT_W+1)'(DEPTH)) begin
                            state_nxt = FS_REQ;
                        end else begin
                            state_nxt = FS_IDLE;
                        end
                    end
                end
                FS_DISCARD: begin
                    if (imem_resp) begin
                        state_nxt = FS_IDLE;
                    end
                end
                default: state_nxt = FS_IDLE;
            endcase
        end
    end

    assign imem_read = (state != FS_IDLE);
    assign imem_addr = (state == FS_DISCARD) ? hold_addr : fetch_pc;
    assign if_valid  = !empty;
    assign if_instr  = empty ? '0 : head.instr;
    assign if_pc     = empty ? '0 : head.pc;
    assign if_pcplus = empty ? '0 : head.pc + ADDR_W'(PC_INC);

`ifdef FETCH_PREFETCH_STATS_EN
    // Saturating counters of decode-starved cycles and redirects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall_cycles <= '0;
            stat_redirects    <= '0;
        end else begin
            if (!if_valid && (stat_stall_cycles != '1)) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
            if (redirect_valid && (stat_redirects != '1)) begin
                stat_redirects <= stat_redirects + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: table-driven cycle vectors for the
// streaming/backpressure case plus directed redirect, wrap and reset sequences.
module tb_fetch_prefetch;

    localparam logic [15:0] K = 16'h5A5A;

    logic        clk;
    logic        rst_n;
    logic        imem_read;
    logic [15:0] imem_addr;
    logic        imem_resp;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pcplus;
    logic        id_ready;

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;

    fetch_prefetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_read      (imem_read),
        .imem_addr      (imem_addr),
        .imem_resp      (imem_resp),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pcplus      (if_pcplus),
        .id_ready       (id_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: response in the mem_lat-th cycle of a held read
    initial begin
        int cnt;
        cnt        = 0;
        imem_resp  = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (imem_read) begin
                cnt = cnt + 1;
                if (cnt >= mem_lat) begin
                    imem_resp  = 1'b1;
                    imem_rdata = imem_addr ^ K;
                    cnt        = 0;
                end else begin
                    imem_resp = 1'b0;
                end
            end else begin
                cnt       = 0;
                imem_resp = 1'b0;
            end
        end
    end

    typedef struct {
        logic        rdy;
        logic        read;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] pc;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Leaves the bench in the first post-reset cycle, before its rising edge
    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        logic found;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;

        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[2]  = '{1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000};
        vecs[3]  = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002};
        vecs[4]  = '{1'b1, 1'b1, 16'h0006, 1'b1, 16'h0004};
        vecs[5]  = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'h0006};
        vecs[6]  = '{1'b0, 1'b1, 16'h000A, 1'b1, 16'h0008};
        vecs[7]  = '{1'b0, 1'b1, 16'h000C, 1'b1, 16'h0008};
        vecs[8]  = '{1'b0, 1'b1, 16'h000E, 1'b1, 16'h0008};
        vecs[9]  = '{1'b0, 1'b0, 16'h0010, 1'b1, 16'h0008};
        vecs[10] = '{1'b1, 1'b0, 16'h0010, 1'b1, 16'h0008};
        vecs[11] = '{1'b1, 1'b0, 16'h0010, 1'b1, 16'h000A};
        vecs[12] = '{1'b1, 1'b1, 16'h0010, 1'b1, 16'h000C};
        vecs[13] = '{1'b1, 1'b1, 16'h0012, 1'b1, 16'h000E};
        vecs[14] = '{1'b1, 1'b1, 16'h0014, 1'b1, 16'h0010};
        vecs[15] = '{1'b1, 1'b1, 16'h0016, 1'b1, 16'h0012};

        // Reset values while rst_n is held low
        #3;
        check("rst_read",   {31'd0, imem_read}, 32'd0);
        check("rst_addr",   {16'd0, imem_addr}, 32'h0000);
        check("rst_valid",  {31'd0, if_valid},  32'd0);
        check("rst_instr",  {16'd0, if_instr},  32'd0);
        check("rst_pc",     {16'd0, if_pc},     32'd0);
        check("rst_pcplus", {16'd0, if_pcplus}, 32'd0);

        // Streaming, then backpressure filling the queue, then resume
        mem_lat = 1;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i > 0) next_cycle();
            id_ready = vecs[i].rdy;
            check($sformatf("vec%0d_read", i),  {31'd0, imem_read}, {31'd0, vecs[i].read});
            check($sformatf("vec%0d_addr", i),  {16'd0, imem_addr}, {16'd0, vecs[i].addr});
            check($sformatf("vec%0d_valid", i), {31'd0, if_valid},  {31'd0, vecs[i].valid});
            check($sformatf("vec%0d_pc", i),    {16'd0, if_pc},     {16'd0, vecs[i].pc});
            if (vecs[i].valid) begin
                check($sformatf("vec%0d_instr", i), {16'd0, if_instr}, {16'd0, vecs[i].pc ^ K});
                check($sformatf("vec%0d_pcplus", i), {16'd0, if_pcplus}, {16'd0, vecs[i].pc + 16'd2});
            end else begin
                check($sformatf("vec%0d_instr", i), {16'd0, if_instr}, 32'd0);
            end
        end

        // Redirect while the read at 0x0008 is outstanding (3-cycle memory)
        mem_lat  = 3;
        id_ready = 1'b1;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            next_cycle();
            if (imem_read && imem_addr == 16'h0008) begin
                found = 1'b1;
                break;
            end
        end
        check("t3_reach_0008", {31'd0, found}, 32'd1);
        check("t3_resp_pending", {31'd0, imem_resp}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h3000;
        next_cycle();
        redirect_valid = 1'b0;
        check("t3_held_read",  {31'd0, imem_read}, 32'd1);
        check("t3_held_addr",  {16'd0, imem_addr}, 32'h0008);
        check("t3_flushed",    {31'd0, if_valid},  32'd0);
        next_cycle();
        check("t3_held_read2", {31'd0, imem_read}, 32'd1);
        check("t3_held_addr2", {16'd0, imem_addr}, 32'h0008);
        check("t3_resp",       {31'd0, imem_resp}, 32'd1);
        next_cycle();
        check("t3_idle_read",  {31'd0, imem_read}, 32'd0);
        check("t3_idle_valid", {31'd0, if_valid},  32'd0);
        next_cycle();
        check("t3_new_read",   {31'd0, imem_read}, 32'd1);
        check("t3_new_addr",   {16'd0, imem_addr}, 32'h3000);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            if (if_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("t3_got_valid", {31'd0, found}, 32'd1);
        check("t3_first_pc",    {16'd0, if_pc},    32'h3000);
        check("t3_first_instr", {16'd0, if_instr}, {16'd0, 16'h3000 ^ K});

        // Redirect coincident with a response and a pop
        mem_lat  = 1;
        id_ready = 1'b1;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            if (imem_read && imem_addr == 16'h0006) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_reach_0006", {31'd0, found}, 32'd1);
        check("t4_resp_now",   {31'd0, imem_resp}, 32'd1);
        check("t4_valid_now",  {31'd0, if_valid},  32'd1);
        check("t4_pc_now",     {16'd0, if_pc},     32'h0004);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h4000;
        next_cycle();
        redirect_valid = 1'b0;
        check("t4_flushed",   {31'd0, if_valid},  32'd0);
        check("t4_idle_read", {31'd0, imem_read}, 32'd0);
        check("t4_idle_addr", {16'd0, imem_addr}, 32'h4000);
        next_cycle();
        check("t4_req_addr",  {16'd0, imem_addr}, 32'h4000);
        check("t4_req_valid", {31'd0, if_valid},  32'd0);
        next_cycle();
        check("t4_first_valid", {31'd0, if_valid}, 32'd1);
        check("t4_first_pc",    {16'd0, if_pc},    32'h4000);
        check("t4_first_instr", {16'd0, if_instr}, {16'd0, 16'h4000 ^ K});

        // PC wrap from 0xFFFE to 0x0000
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        next_cycle();
        redirect_valid = 1'b0;
        check("t5_idle_addr", {16'd0, imem_addr}, 32'hFFFE);
        next_cycle();
        check("t5_req_addr",  {16'd0, imem_addr}, 32'hFFFE);
        check("t5_req_read",  {31'd0, imem_read}, 32'd1);
        next_cycle();
        check("t5_wrap_addr", {16'd0, imem_addr}, 32'h0000);
        check("t5_head_pc",   {16'd0, if_pc},     32'hFFFE);
        check("t5_head_plus", {16'd0, if_pcplus}, 32'h0000);
        check("t5_head_inst", {16'd0, if_instr},  {16'd0, 16'hFFFE ^ K});

        // Asynchronous reset in the middle of a read
        mem_lat  = 3;
        id_ready = 1'b0;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            next_cycle();
            if (if_valid && imem_read) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_pre_state", {31'd0, found}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_read",  {31'd0, imem_read}, 32'd0);
        check("t6_async_valid", {31'd0, if_valid},  32'd0);
        check("t6_async_addr",  {16'd0, imem_addr}, 32'h0000);
        next_cycle();
        rst_n = 1'b1;
        check("t6_rel_addr", {16'd0, imem_addr}, 32'h0000);
        check("t6_rel_read", {31'd0, imem_read}, 32'd0);
        next_cycle();
        check("t6_reissue_read", {31'd0, imem_read}, 32'd1);
        check("t6_reissue_addr", {16'd0, imem_addr}, 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
